uart_tx_slave: RTL and testbench

//  MemoryBus responder for the UART window (4 words at 'h800 on the slave bus mux).

---
 rtl/uart_tx_slave_if.sv | 20 ++
 rtl/uart_tx_slave.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_slave.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_slave_if.sv
// Memory-bus command/result bundle for the UART slave window.
// The master drives the command fields and the slave returns read_data.
interface uart_tx_slave_if;
   logic [29:0] address;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mask_byte;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (
      output address, mem_read, mem_write, mask_byte, write_data,
      input  read_data
   );

   modport slave (
      input  address, mem_read, mem_write, mask_byte, write_data,
      output read_data
   );
endinterface

// File: rtl/uart_tx_slave.sv
// Memory-mapped UART transmitter: TX FIFO fed from the bus, serialised as 8N1 frames, LSB first.
// Registers: 0 TXDATA, 1 STATUS, 2 BAUD_DIV, 3 CTRL.
module uart_tx_slave #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned DEFAULT_DIV = 434
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_slave_if.slave    membus,
   output logic              tx,
   output logic              tx_empty
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = PW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic          overflow;
   logic [15:0]   baud_div;
   logic          enable;
   logic [15:0]   cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   logic [1:0]    sel;
   logic          full;
   logic          empty;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          bit_end;
   logic [15:0]   reload;
   logic [15:0]   baud_new;
   logic [31:0]   rdata_c;

   wire unused_bits = ^{membus.address[29:2], membus.write_data[31:16], membus.mask_byte[3:2]};

   assign sel      = membus.address[1:0];
   assign full     = (level == LW'(FIFO_DEPTH));
   assign empty    = (level == '0);
   assign push_req = membus.mem_write && (sel == 2'd0) && membus.mask_byte[0];
   assign push     = push_req && !full;
   assign bit_end  = (cnt == 16'd0);
   assign reload   = baud_div - 16'd1;
   assign tx_empty = empty && (state == IDLE);

   // Pop happens from IDLE, or back-to-back at the end of a stop bit
   assign pop = enable && !empty && ((state == IDLE) || ((state == STOP) && bit_end));

   // Byte-lane merge for BAUD_DIV; zero would stall the bit counter, so it is stored as 1
   always_comb begin
      baud_new = baud_div;
      if (membus.mask_byte[0]) baud_new[7:0]  = membus.write_data[7:0];
      if (membus.mask_byte[1]) baud_new[15:8] = membus.write_data[15:8];
      if (baud_new == 16'd0)   baud_new       = 16'd1;
   end

   always_comb begin
      rdata_c = '0;
      case (sel)
         2'd1: begin
            rdata_c[0]       = (state != IDLE);
            rdata_c[1]       = full;
            rdata_c[2]       = empty;
            rdata_c[3]       = overflow;
            rdata_c[4 +: LW] = level;
         end
         2'd2:    rdata_c[15:0] = baud_div;
         2'd3:    rdata_c[0]    = enable;
         default: rdata_c       = '0;
      endcase
   end

   assign membus.read_data = membus.mem_read ? rdata_c : 32'd0;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= membus.write_data[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         baud_div <= 16'(DEFAULT_DIV);
         enable   <= 1'b1;
         cnt      <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase

         // Clear-on-write-1, but a same-edge dropped push still flags overflow
         if (membus.mem_write && (sel == 2'd1) && membus.mask_byte[0] && membus.write_data[3])
            overflow <= 1'b0;
         if (push_req && full)
            overflow <= 1'b1;

         if (membus.mem_write && (sel == 2'd2) && (membus.mask_byte[1:0] != 2'b00))
            baud_div <= baud_new;
         if (membus.mem_write && (sel == 2'd3) && membus.mask_byte[0])
            enable <= membus.write_data[0];

         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shift <= fifo_mem[rd_ptr];
                  cnt   <= reload;
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= reload;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= DATA;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= reload;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift[1];
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     shift <= fifo_mem[rd_ptr];
                     cnt   <= reload;
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_slave.sv
// Directed bench for uart_tx_slave: register access, frame timing, FIFO full/overflow and reset abort.
module tb_uart_tx_slave;
   logic clk = 1'b0;
   logic rst;
   logic tx;
   logic tx_empty;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] rd;
   logic [7:0]  bytes3 [3];
   logic [7:0]  bytes9 [9];

   uart_tx_slave_if bus ();

   uart_tx_slave dut (
      .clk      (clk),
      .rst      (rst),
      .membus   (bus),
      .tx       (tx),
      .tx_empty (tx_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
      bus.address    = 30'(a);
      bus.write_data = d;
      bus.mask_byte  = m;
      bus.mem_write  = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_write  = 1'b0;
      bus.mask_byte  = 4'h0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus.address  = 30'(a);
      bus.mem_read = 1'b1;
      #1;
      d = bus.read_data;
      bus.mem_read = 1'b0;
   endtask

   // Frame bit i of an 8N1 frame: start, d0..d7, stop
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i == 9) return 1'b1;
      return b[i-1];
   endfunction

   initial begin
      bus.address    = '0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mask_byte  = 4'h0;
      bus.write_data = '0;
      bytes3 = '{8'h3C, 8'h81, 8'hE6};
      for (int i = 0; i < 9; i++) bytes9[i] = 8'(8'h11 * i + 8'h02);

      // Reset
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_tx_empty", 32'(tx_empty), 32'd1);
      bus_read(2'd1, rd); check("reset_status", rd, 32'h4);
      bus_read(2'd2, rd); check("reset_baud", rd, 32'd434);
      bus_read(2'd3, rd); check("reset_ctrl", rd, 32'd1);
      bus_read(2'd0, rd); check("txdata_reads_zero", rd, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Single frame 0xA5 at BAUD_DIV=4
      bus_write(2'd2, 32'd4, 4'b0011);
      bus_read(2'd2, rd); check("baud_4", rd, 32'd4);
      bus_write(2'd0, 32'hA5, 4'b0001);
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         check($sformatf("a5_bit%0d_c%0d", c / 4, c % 4), 32'(tx), 32'(frame_bit(8'hA5, c / 4)));
         if (c == 5) begin
            bus_read(2'd1, rd); check("a5_busy", rd, 32'h5);
         end
      end
      check("a5_not_empty_in_stop", 32'(tx_empty), 32'd0);
      @(posedge clk); #1;
      check("a5_tx_empty", 32'(tx_empty), 32'd1);

      // Three back-to-back frames at BAUD_DIV=2
      bus_write(2'd2, 32'd2, 4'b0011);
      bus_write(2'd0, 32'(bytes3[0]), 4'b0001);
      for (int c = 0; c < 60; c++) begin
         if (c < 2) begin
            bus.address    = 30'd0;
            bus.write_data = 32'(bytes3[c+1]);
            bus.mask_byte  = 4'b0001;
            bus.mem_write  = 1'b1;
         end
         @(posedge clk); #1;
         bus.mem_write = 1'b0;
         bus.mask_byte = 4'h0;
         check($sformatf("b2b_f%0d_bit%0d", c / 20, (c % 20) / 2), 32'(tx),
               32'(frame_bit(bytes3[c / 20], (c % 20) / 2)));
         if (c % 20 == 1) begin
            bus_read(2'd1, rd);
            check($sformatf("b2b_level_f%0d", c / 20), 32'(rd[7:4]), 32'(2 - c / 20));
         end
      end
      @(posedge clk); #1;
      check("b2b_tx_empty", 32'(tx_empty), 32'd1);

      // Fill past full with enable=0, clear overflow, then drain
      bus_write(2'd3, 32'd0, 4'b0001);
      for (int i = 0; i < 9; i++) bus_write(2'd0, 32'(bytes9[i]), 4'b0001);
      bus_read(2'd1, rd); check("full_status", rd, 32'h8A);
      check("full_tx_idle", 32'(tx), 32'd1);
      bus_write(2'd1, 32'h8, 4'b0001);
      bus_read(2'd1, rd); check("ovf_cleared", rd, 32'h82);
      bus_write(2'd3, 32'd1, 4'b0001);
      for (int c = 0; c < 160; c++) begin
         @(posedge clk); #1;
         check($sformatf("drain_f%0d_bit%0d", c / 20, (c % 20) / 2), 32'(tx),
               32'(frame_bit(bytes9[c / 20], (c % 20) / 2)));
      end
      @(posedge clk); #1;
      check("drain_tx_empty", 32'(tx_empty), 32'd1);
      bus_read(2'd1, rd); check("drain_status", rd, 32'h4);
      repeat (10) @(posedge clk);
      #1;
      check("no_ninth_frame", 32'(tx), 32'd1);

      // Masked TXDATA write and BAUD_DIV boundaries
      bus_write(2'd0, 32'h55, 4'b0010);
      bus_read(2'd1, rd); check("masked_no_push", rd, 32'h4);
      @(posedge clk); #1;
      check("masked_tx_idle", 32'(tx), 32'd1);
      bus_write(2'd2, 32'd0, 4'b0011);
      bus_read(2'd2, rd); check("baud_zero_is_one", rd, 32'd1);
      bus_write(2'd2, 32'h1203, 4'b0001);
      bus_read(2'd2, rd); check("baud_lane0_only", rd, 32'd3);

      // Reset during DATA bit 3 of a 0x00 frame at BAUD_DIV=3
      bus_write(2'd0, 32'h00, 4'b0001);
      repeat (13) @(posedge clk);
      #1;
      check("abort_bit3_low", 32'(tx), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_tx_high", 32'(tx), 32'd1);
      check("abort_tx_empty", 32'(tx_empty), 32'd1);
      rst = 1'b1;
      bus_read(2'd1, rd); check("abort_status", rd, 32'h4);
      bus_read(2'd2, rd); check("abort_baud", rd, 32'd434);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         check($sformatf("abort_idle_c%0d", c), 32'(tx), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
